// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// Decode-to-execute pipeline register for one VLIW issue slot. Captures the
// decoded operands and control of the slot and produces the registered 2-bit
// selects for the downstream 4:1 operand muxes:
//   00 = register-file data (out_op_a / out_op_b)
//   01 = EX/MEM result
//   10 = MEM/WB result
//   11 = immediate (out_imm), operand B only
// It also detects RAW hazards and inserts bubbles. Instantiate once per slot.
//
// Build option:
//   ID_EX_FORWARD_EN  defined   -> full forwarding; only load-use stalls.
//                     undefined -> no forwarding; any RAW dependency on the
//                                  EX or EX/MEM destination stalls decode
//                                  (writeback is write-before-read).
//
// Parameters:
//   CTRL_W  width of the opaque execute control bundle
//   REG_AW  register index width (index 0 is hardwired zero)
//   DATA_W  operand data width
//
// Ports:
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   in_valid            decode slot holds a valid instruction
//   in_rs1/in_rs2/in_rd source A/B and destination indices
//   in_wen, in_is_load  instruction writes in_rd / is a load
//   in_use_imm          operand B comes from the immediate
//   in_rs1_data/in_rs2_data/in_imm  operand data and immediate
//   in_ctrl             execute control bundle
//   stall               global freeze from later stages (hold everything)
//   flush               kill the instruction being captured
//   exmem_rd/exmem_wen  destination of the instruction in EX/MEM
//   out_*               registered EX-slot copies, operand selects
//   hazard_stall        combinational: hold PC and decode this cycle
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    input  logic              in_is_load,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_wen,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [1:0]        out_sel_a,
    output logic [1:0]        out_sel_b,
    output logic              hazard_stall
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    // A source depends on a producer only if the producer writes and the
    // index is a real register (r0 never carries a dependency).
    function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              dst_wen);
        return dst_wen && (src != '0) && (src == dst);
    endfunction

    // Priority select for one source: the younger producer (now in EX, about
    // to be EX/MEM) wins over the older one (now in EX/MEM, about to be MEM/WB).
    function automatic logic [1:0] fwd_sel(input logic ex_hit,
                                           input logic mw_hit);
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex_hit)
            sel = SEL_EXMEM;
        else if (mw_hit)
            sel = SEL_MEMWB;
        return sel;
    endfunction

    // EX-slot registers
    logic              valid_p1;
    logic [REG_AW-1:0] rd_p1;
    logic              wen_p1;
    logic              is_load_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] op_a_p1;
    logic [DATA_W-1:0] op_b_p1;
    logic [DATA_W-1:0] imm_p1;
    logic [1:0]        sel_a_p1;
    logic [1:0]        sel_b_p1;

    // Dependency terms of the decode instruction
    logic       ex_wr;
    logic       rs2_used;
    logic       ex_hit_a;
    logic       ex_hit_b;
    logic       mw_hit_a;
    logic       mw_hit_b;
    logic       hazard_raw;
    logic       kill;
    logic [1:0] sel_a_d;
    logic [1:0] sel_b_d;

    // A bubble in EX (valid=0 or wen=0) never produces a result.
    assign ex_wr    = valid_p1 & wen_p1;
    assign rs2_used = ~in_use_imm;

    assign ex_hit_a = src_hit(in_rs1, rd_p1, ex_wr);
    assign ex_hit_b = rs2_used & src_hit(in_rs2, rd_p1, ex_wr);
    assign mw_hit_a = src_hit(in_rs1, exmem_rd, exmem_wen);
    assign mw_hit_b = rs2_used & src_hit(in_rs2, exmem_rd, exmem_wen);

`ifdef ID_EX_FORWARD_EN
    // Only a load in EX is too late to forward from EX/MEM.
    assign hazard_raw = in_valid & is_load_p1 & (ex_hit_a | ex_hit_b);
    assign sel_a_d    = fwd_sel(ex_hit_a, mw_hit_a);
    assign sel_b_d    = in_use_imm ? SEL_IMM : fwd_sel(ex_hit_b, mw_hit_b);
`else
    // Without forwarding, any in-flight producer of a source blocks decode
    // until it has reached writeback.
    assign hazard_raw = in_valid & (ex_hit_a | ex_hit_b | mw_hit_a | mw_hit_b);
    assign sel_a_d    = SEL_RF;
    assign sel_b_d    = in_use_imm ? SEL_IMM : SEL_RF;
`endif

    // A global stall freezes the whole pipe, and a flush kills the decode
    // instruction anyway, so neither should also hold the PC.
    assign hazard_stall = hazard_raw & ~stall & ~flush;

    // Anything that is not a live, hazard-free instruction enters EX as a bubble.
    assign kill = flush | hazard_raw | ~in_valid;

    // ---- decode -> execute boundary ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_p1   <= 1'b0;
            rd_p1      <= '0;
            wen_p1     <= 1'b0;
            is_load_p1 <= 1'b0;
            ctrl_p1    <= '0;
            op_a_p1    <= '0;
            op_b_p1    <= '0;
            imm_p1     <= '0;
            sel_a_p1   <= SEL_RF;
            sel_b_p1   <= SEL_RF;
        end else if (!stall) begin
            valid_p1   <= ~kill;
            wen_p1     <= in_wen & ~kill;
            is_load_p1 <= in_is_load & ~kill;
            // Payload of a bubble is irrelevant; capture it unconditionally.
            rd_p1      <= in_rd;
            ctrl_p1    <= in_ctrl;
            op_a_p1    <= in_rs1_data;
            op_b_p1    <= in_rs2_data;
            imm_p1     <= in_imm;
            sel_a_p1   <= sel_a_d;
            sel_b_p1   <= sel_b_d;
        end
    end

    assign out_valid   = valid_p1;
    assign out_rd      = rd_p1;
    assign out_wen     = wen_p1;
    assign out_is_load = is_load_p1;
    assign out_ctrl    = ctrl_p1;
    assign out_op_a    = op_a_p1;
    assign out_op_b    = op_b_p1;
    assign out_imm     = imm_p1;
    assign out_sel_a   = sel_a_p1;
    assign out_sel_b   = sel_b_p1;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// of the EX slot. Works for both builds (ID_EX_FORWARD_EN defined or not).
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_wen, in_is_load, in_use_imm;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic [7:0]  in_ctrl;
    logic        stall, flush;
    logic [4:0]  exmem_rd;
    logic        exmem_wen;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_wen, out_is_load;
    logic [7:0]  out_ctrl;
    logic [31:0] out_op_a, out_op_b, out_imm;
    logic [1:0]  out_sel_a, out_sel_b;
    logic        hazard_stall;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_wen(in_wen), .in_is_load(in_is_load), .in_use_imm(in_use_imm),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_wen(exmem_wen),
        .out_valid(out_valid), .out_rd(out_rd), .out_wen(out_wen),
        .out_is_load(out_is_load), .out_ctrl(out_ctrl),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
        .out_sel_a(out_sel_a), .out_sel_b(out_sel_b),
        .hazard_stall(hazard_stall)
    );

    // ---------------- behavioural model of the EX slot ----------------
    typedef struct packed {
        bit        known;   // a reset has been seen
        bit        dc;      // bubble: payload is don't-care
        bit        valid;
        bit        wen;
        bit        is_load;
        bit [4:0]  rd;
        bit [7:0]  ctrl;
        bit [31:0] a;
        bit [31:0] b;
        bit [31:0] imm;
        bit [1:0]  sa;
        bit [1:0]  sb;
    } ex_t;

    ex_t m = '0;

    // Does decode read register r (written when w)?
    function automatic bit reads(bit w, bit [4:0] r);
        return w && r != 0 && (r == in_rs1 || (!in_use_imm && r == in_rs2));
    endfunction

    function automatic bit hz_raw(ex_t e);
`ifdef ID_EX_FORWARD_EN
        return in_valid && e.valid && e.is_load && reads(e.wen, e.rd);
`else
        return in_valid && (reads(e.valid && e.wen, e.rd) || reads(exmem_wen, exmem_rd));
`endif
    endfunction

    function automatic bit [1:0] src_sel(ex_t e, bit [4:0] s);
`ifdef ID_EX_FORWARD_EN
        if (s == 0) return 2'd0;
        if (e.valid && e.wen && e.rd == s) return 2'd1;
        if (exmem_wen && exmem_rd == s) return 2'd2;
`endif
        return 2'd0;
    endfunction

    function automatic ex_t model_next(ex_t e);
        ex_t n;
        n = e;
        if (!reset_n) begin
            n = '0;
            n.known = 1'b1;
        end else if (stall) begin
            n = e;
        end else if (flush || !in_valid || hz_raw(e)) begin
            n.valid = 0; n.wen = 0; n.is_load = 0; n.dc = 1;
        end else begin
            n.dc = 0; n.valid = 1; n.wen = in_wen; n.is_load = in_is_load;
            n.rd = in_rd; n.ctrl = in_ctrl; n.a = in_rs1_data; n.b = in_rs2_data;
            n.imm = in_imm;
            n.sa = src_sel(e, in_rs1);
            n.sb = in_use_imm ? 2'd3 : src_sel(e, in_rs2);
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs and hazard_stall against the model each cycle.
    always @(negedge clk) begin
        if (m.known) begin
            check("m_valid", 32'(out_valid), 32'(m.valid));
            check("m_wen", 32'(out_wen), 32'(m.wen));
            check("m_is_load", 32'(out_is_load), 32'(m.is_load));
            if (!m.dc) begin
                check("m_rd", 32'(out_rd), 32'(m.rd));
                check("m_ctrl", 32'(out_ctrl), 32'(m.ctrl));
                check("m_op_a", out_op_a, m.a);
                check("m_op_b", out_op_b, m.b);
                check("m_imm", out_imm, m.imm);
                check("m_sel_a", 32'(out_sel_a), 32'(m.sa));
                check("m_sel_b", 32'(out_sel_b), 32'(m.sb));
            end
            check("m_hazard", 32'(hazard_stall), 32'(hz_raw(m) && !stall && !flush));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input bit w, input bit ld, input bit im);
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = d;
        in_wen = w; in_is_load = ld; in_use_imm = im;
        in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
        in_ctrl = 8'($urandom);
    endtask

    // Advance past the next capture edge; outputs are then stable.
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_hz(input string name, input bit exp);
        #1;
        check(name, 32'(hazard_stall), 32'(exp));
    endtask

    logic [31:0] ea;

    initial begin
        reset_n = 0; stall = 0; flush = 0; exmem_rd = 0; exmem_wen = 0;
        drive(1, 1, 2, 3, 1, 0, 0);

        // Reset held two cycles with a valid instruction present.
        next();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_op_a", out_op_a, 0);
        check("rst_sel_b", 32'(out_sel_b), 0);
        drive(1, 1, 2, 3, 1, 1, 1);
        next();
        check("rst2_valid", 32'(out_valid), 0);
        check("rst2_ctrl", 32'(out_ctrl), 0);
        check("rst2_rd", 32'(out_rd), 0);
        reset_n = 1;
        drive(1, 1, 2, 1, 0, 0, 0);
        ea = in_rs1_data;
        next();
        check("rel_valid", 32'(out_valid), 1);
        check("rel_op_a", out_op_a, ea);

        // ALU producer rd=5 in EX, exmem_rd=7, decode rs1=5 rs2=7.
        drive(1, 1, 1, 5, 1, 0, 0);
        next();
        drive(1, 5, 7, 0, 0, 0, 0);
        exmem_rd = 7; exmem_wen = 1;
`ifdef ID_EX_FORWARD_EN
        chk_hz("fw_hz", 0);
        next();
        check("fw_sel_a", 32'(out_sel_a), 1);
        check("fw_sel_b", 32'(out_sel_b), 2);

        // Both older and younger producers write r3: younger wins.
        exmem_wen = 0;
        drive(1, 1, 1, 3, 1, 0, 0);
        next();
        drive(1, 3, 0, 0, 1, 0, 0);
        exmem_rd = 3; exmem_wen = 1;
        next();
        check("young_sel_a", 32'(out_sel_a), 1);
        check("young_sel_b", 32'(out_sel_b), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        exmem_rd = 0;
        next();
        check("r0_sel_a", 32'(out_sel_a), 0);
        check("r0_sel_b", 32'(out_sel_b), 0);
`else
        chk_hz("nf_hz", 1);
        next();
        check("nf_bubble", 32'(out_valid), 0);
        // Producer now in EX/MEM: still blocked.
        exmem_rd = 5; exmem_wen = 1;
        chk_hz("nf_hz2", 1);
        next();
        check("nf_bubble2", 32'(out_valid), 0);
        // Producer gone: decode issues with register-file selects.
        exmem_wen = 0;
        chk_hz("nf_hz3", 0);
        next();
        check("nf_valid", 32'(out_valid), 1);
        check("nf_sel_a", 32'(out_sel_a), 0);
        check("nf_sel_b", 32'(out_sel_b), 0);
`endif

        // Load-use: load rd=9 in EX, decode reads r9 as operand B.
        exmem_wen = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        next();
        drive(1, 1, 1, 9, 1, 1, 0);
        next();
        drive(1, 1, 9, 2, 1, 0, 0);
        chk_hz("ld_hz", 1);
        next();
        check("ld_bubble", 32'(out_valid), 0);
        check("ld_bubble_wen", 32'(out_wen), 0);
        // The load has moved on to EX/MEM.
        exmem_rd = 9; exmem_wen = 1;
`ifdef ID_EX_FORWARD_EN
        chk_hz("ld_hz2", 0);
        next();
        check("ld_valid", 32'(out_valid), 1);
        check("ld_sel_b", 32'(out_sel_b), 2);
`else
        chk_hz("ld_hz2", 1);
        next();
        check("ld_bubble2", 32'(out_valid), 0);
        exmem_wen = 0;
        chk_hz("ld_hz3", 0);
        next();
        check("ld_valid", 32'(out_valid), 1);
        check("ld_sel_b", 32'(out_sel_b), 0);
`endif
        // Same load-use shape but operand B is the immediate.
        exmem_wen = 0;
        drive(1, 1, 1, 9, 1, 1, 0);
        next();
        drive(1, 1, 9, 2, 1, 0, 1);
        chk_hz("imm_hz", 0);
        next();
        check("imm_valid", 32'(out_valid), 1);
        check("imm_sel_b", 32'(out_sel_b), 3);
        check("imm_sel_a", 32'(out_sel_a), 0);

        // Stall holds everything; hazard_stall gated by stall and flush.
        drive(1, 0, 0, 4, 1, 1, 0);
        ea = in_rs1_data;
        next();
        check("st_cap", out_op_a, ea);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4, 4, 6, 1, 0, 0);
            chk_hz("st_hz", 0);
            next();
            check("st_op_a", out_op_a, ea);
            check("st_rd", 32'(out_rd), 4);
            check("st_valid", 32'(out_valid), 1);
        end
        flush = 1;
        next();
        check("stfl_op_a", out_op_a, ea);
        check("stfl_valid", 32'(out_valid), 1);
        stall = 0;
        chk_hz("fl_hz", 0);
        next();
        check("fl_valid", 32'(out_valid), 0);
        check("fl_wen", 32'(out_wen), 0);
        flush = 0;

        // Reset while stalled: reset wins.
        drive(1, 0, 0, 7, 1, 0, 0);
        next();
        stall = 1; reset_n = 0;
        next();
        check("rst_st_valid", 32'(out_valid), 0);
        check("rst_st_op_a", out_op_a, 0);
        stall = 0; reset_n = 1;

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset_n    = ($urandom_range(0, 99) >= 2);
            stall      = ($urandom_range(0, 99) < 15);
            flush      = ($urandom_range(0, 99) < 10);
            exmem_rd   = 5'($urandom_range(0, 3));
            exmem_wen  = ($urandom_range(0, 99) < 60);
            drive($urandom_range(0, 99) < 80,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30);
            next();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
